// File: rtl/instr_sequencer.sv
// Instruction sequencer: FIFO-buffered issue to a datapath with done handshake and post-done gap.
// Optional WAIT_DONE watchdog enabled by defining INSTR_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module instr_sequencer #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [17:0]              push_instr,
  input  logic                     flush,
  input  logic                     issue_ready,
  input  logic                     done,
  output logic                     issue_valid,
  output logic [17:0]              issue_instr,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  output logic                     timeout
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_sequencer: DEPTH must be a power of two in 2..16");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("instr_sequencer: GAP_CYCLES must be in 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("instr_sequencer: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t              state, next_state;
  logic [17:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          gap_cnt;
  logic [17:0]         head;
  logic                is_full, is_empty;
  logic                pop, clear_pop, push_acc, push_rej;
  logic                wd_expire;

  assign head     = mem[rd_ptr];
  assign is_full  = (cnt == CNT_W'(DEPTH));
  assign is_empty = (cnt == '0);

  // Flush beats any same-cycle pop/push; a popped CLEAR discards everything behind it.
  assign pop       = (state == ISSUE) && issue_ready && !flush;
  assign clear_pop = pop && (head[17:15] == OP_CLEAR);
  assign push_acc  = push && !flush && !clear_pop && (!is_full || pop);
  assign push_rej  = push && !flush && is_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= push_rej;
      if (flush || clear_pop) begin
        rd_ptr <= wr_ptr;
        cnt    <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + 1'b1;
        if (pop)      rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CNT_W'(push_acc) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= next_state;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (!is_empty && !flush) next_state = ISSUE;
      ISSUE: begin
        if (flush)            next_state = IDLE;
        else if (issue_ready) next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done)           next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
        else if (wd_expire) next_state = IDLE;
      end
      GAP:       if (gap_cnt == GAP_LAST) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    issue_valid = 1'b0;
    issue_instr = '0;
    busy        = (state == WAIT_DONE) || (state == GAP);
    full        = is_full;
    empty       = is_empty;
    count       = cnt;
    if (state == ISSUE) begin
      issue_valid = 1'b1;
      issue_instr = head;
    end
  end

`ifdef INSTR_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;
  logic        timeout_q;

  // Watchdog counts consecutive WAIT_DONE cycles; a late done on the expiry cycle still wins.
  assign wd_expire = (state == WAIT_DONE) && !done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (state == WAIT_DONE && next_state == WAIT_DONE) wd_cnt <= wd_cnt + 16'd1;
      else                                                wd_cnt <= '0;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: reset, issue/gap timing, FIFO full/drop,
// CLEAR opcode, flush priority, reset mid-flight and (with INSTR_SEQ_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps

module tb_instr_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
`ifdef INSTR_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic [17:0]   push_instr = '0;
  logic          flush = 1'b0;
  logic          issue_ready = 1'b0;
  logic          done = 1'b0;
  logic          issue_valid;
  logic [17:0]   issue_instr;
  logic          busy, full, empty;
  logic [CW-1:0] count;
  logic          drop_err, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  instr_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .push(push), .push_instr(push_instr), .flush(flush),
    .issue_ready(issue_ready), .done(done), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .busy(busy), .full(full), .empty(empty),
    .count(count), .drop_err(drop_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input int i);
    mk = {3'b001, 4'(i), 4'd0, 7'(i)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    push = 0; flush = 0; done = 0; issue_ready = 0; push_instr = '0;
    reset = 1;
    tick;
    reset = 0;
    tick;
  endtask

  task automatic test_reset;
    push = 0; flush = 0; done = 0; issue_ready = 0;
    reset = 1;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid got %b want 0", issue_valid); end
    n_checks++; if (issue_instr !== 18'h0) begin n_fail++; $display("[TB] FAIL rst_instr got %h want 0", issue_instr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_full got %b want 0", full); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_empty got %b want 1", empty); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_count got %0d want 0", count); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_drop got %b want 0", drop_err); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_timeout got %b want 0", timeout); end
    tick;
    reset = 0;
    tick;
  endtask

  task automatic test_single_issue;
    apply_reset;
    issue_ready = 1; push = 1; push_instr = 18'h0A005;
    tick;
    push = 0;
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("[TB] FAIL single_count1 got %0d want 1", count); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_valid got %b want 0", issue_valid); end
    tick;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid got %b want 1", issue_valid); end
    n_checks++; if (issue_instr !== 18'h0A005) begin n_fail++; $display("[TB] FAIL single_instr got %h want 0a005", issue_instr); end
    tick;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_drop got %b want 0", issue_valid); end
    n_checks++; if (issue_instr !== 18'h0) begin n_fail++; $display("[TB] FAIL single_instr_zero got %h want 0", issue_instr); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL single_count0 got %0d want 0", count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_wait got %b want 1", busy); end
    tick; tick;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_hold got %b want 1", busy); end
    done = 1;
    tick;
    done = 0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_gap1 got %b want 1", busy); end
    tick;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_gap2 got %b want 1", busy); end
    tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_gap_end got %b want 0", busy); end
  endtask

  task automatic test_fill_and_drop;
    apply_reset;
    issue_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      push = 1; push_instr = mk(i);
      tick;
      if (i <= 8) begin
        n_checks++; if (count !== 4'(i)) begin n_fail++; $display("[TB] FAIL fill_count%0d got %0d want %0d", i, count, i); end
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_nodrop%0d got %b want 0", i, drop_err); end
      end else begin
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL fill_count9 got %0d want 8", count); end
        n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_drop got %b want 1", drop_err); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full got %b want 1", full); end
      end
    end
    push = 0;
    tick;
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_drop_pulse got %b want 0", drop_err); end
    issue_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      int waited = 0;
      while (!issue_valid && waited < 20) begin tick; waited++; end
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_wait%0d got %b want 1", i, issue_valid); end
      n_checks++; if (issue_instr !== mk(i)) begin n_fail++; $display("[TB] FAIL drain_order%0d got %h want %h", i, issue_instr, mk(i)); end
      tick;
      n_checks++; if (count !== 4'(8 - i)) begin n_fail++; $display("[TB] FAIL drain_count%0d got %0d want %0d", i, count, 8 - i); end
      done = 1;
      tick;
      done = 0;
    end
    tick; tick; tick;
    n_checks++; if (empty !== 1'b1 || issue_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_final got empty=%b valid=%b want 1/0", empty, issue_valid); end
  endtask

  task automatic test_full_push_pop;
    apply_reset;
    issue_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      push = 1; push_instr = mk(i);
      tick;
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_full got %b want 1", full); end
    push = 1; push_instr = mk(9); issue_ready = 1;
    tick;
    push = 0; issue_ready = 0;
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("[TB] FAIL pp_count got %0d want 8", count); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_nodrop got %b want 0", drop_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_busy got %b want 1", busy); end
    flush = 1;
    tick;
    flush = 0;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL pp_flush_count got %0d want 0", count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_flush_wait got %b want 1", busy); end
    done = 1;
    tick;
    done = 0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_gap got %b want 1", busy); end
    tick; tick; tick;
    n_checks++; if (busy !== 1'b0 || issue_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_idle got busy=%b valid=%b want 0/0", busy, issue_valid); end
  endtask

  task automatic test_clear;
    logic [17:0] w_load, w_clear, w_add, w_sub;
    int waited;
    logic saw_issue;
    w_load  = {3'b001, 4'd1, 4'd2, 7'd3};
    w_clear = {3'b110, 4'd0, 4'd0, 7'd0};
    w_add   = {3'b010, 4'd4, 4'd5, 7'd6};
    w_sub   = {3'b011, 4'd7, 4'd8, 7'd9};
    apply_reset;
    issue_ready = 0;
    push = 1; push_instr = w_load;  tick;
    push_instr = w_clear; tick;
    push_instr = w_add;   tick;
    push_instr = w_sub;   tick;
    push = 0;
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("[TB] FAIL clr_count4 got %0d want 4", count); end
    n_checks++; if (issue_instr !== w_load) begin n_fail++; $display("[TB] FAIL clr_head got %h want %h", issue_instr, w_load); end
    issue_ready = 1;
    tick;
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("[TB] FAIL clr_count3 got %0d want 3", count); end
    done = 1;
    tick;
    done = 0;
    waited = 0;
    while (!issue_valid && waited < 20) begin tick; waited++; end
    n_checks++; if (issue_instr !== w_clear) begin n_fail++; $display("[TB] FAIL clr_issue got %h want %h", issue_instr, w_clear); end
    tick;
    n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_flushed got count=%0d empty=%b want 0/1", count, empty); end
    done = 1;
    tick;
    done = 0;
    saw_issue = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (issue_valid) saw_issue = 1'b1;
    end
    n_checks++; if (saw_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_no_issue got %b want 0", saw_issue); end
    issue_ready = 0;
  endtask

  task automatic test_flush_push;
    apply_reset;
    issue_ready = 0;
    push = 1; push_instr = mk(5);
    tick;
    push = 0;
    tick;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL fp_issue got %b want 1", issue_valid); end
    flush = 1; push = 1; push_instr = mk(6);
    tick;
    flush = 0; push = 0;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("[TB] FAIL fp_count got %0d want 0", count); end
    n_checks++; if (issue_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_idle got valid=%b busy=%b want 0/0", issue_valid, busy); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_nodrop got %b want 0", drop_err); end
    tick; tick;
    n_checks++; if (issue_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fp_stay got valid=%b empty=%b want 0/1", issue_valid, empty); end
  endtask

  task automatic test_reset_mid_wait;
    apply_reset;
    issue_ready = 1;
    push = 1; push_instr = mk(7); tick;
    push_instr = mk(8); tick;
    push = 0;
    tick;
    n_checks++; if (busy !== 1'b1 || count !== 4'd1) begin n_fail++; $display("[TB] FAIL rmw_pre got busy=%b count=%0d want 1/1", busy, count); end
    reset = 1;
    #1;
    n_checks++; if (busy !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rmw_async got busy=%b count=%0d empty=%b want 0/0/1", busy, count, empty); end
    n_checks++; if (issue_valid !== 1'b0 || issue_instr !== 18'h0 || timeout !== 1'b0 || drop_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rmw_outs got valid=%b instr=%h to=%b drop=%b want 0", issue_valid, issue_instr, timeout, drop_err); end
    tick;
    reset = 0;
    done = 1;
    tick;
    done = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rmw_done_ignored got %b want 0", busy); end
    tick; tick;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rmw_no_issue got %b want 0", issue_valid); end
    issue_ready = 0;
  endtask

`ifdef INSTR_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    apply_reset;
    issue_ready = 1;
    push = 1; push_instr = mk(10); tick;
    push_instr = mk(11); tick;
    push = 0;
    tick;
    for (int k = 1; k < 16; k++) tick;
    n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL to_before got to=%b busy=%b want 0/1", timeout, busy); end
    tick;
    n_checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL to_pulse got to=%b busy=%b want 1/0", timeout, busy); end
    tick;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_once got %b want 0", timeout); end
    n_checks++; if (issue_valid !== 1'b1 || issue_instr !== mk(11)) begin n_fail++; $display("[TB] FAIL to_next got valid=%b instr=%h want 1/%h", issue_valid, issue_instr, mk(11)); end
    issue_ready = 0;
  endtask
`endif

  initial begin
    $display("[TB] instr_sequencer directed test start");
    test_reset;
    test_single_issue;
    test_fill_and_drop;
    test_full_push_pop;
    test_clear;
    test_flush_push;
    test_reset_mid_wait;
`ifdef INSTR_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
